axi_burst_master: RTL and testbench

//  AXI4 full master that turns a start pulse into one fixed-length INCR burst write or read at a fixed target address.

---
 rtl/axi_burst_master.sv | 211 +++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// AXI4 master that turns a txn_start edge into one fixed-length INCR write or read burst at a fixed address.
// Optional feature: define READ_CHECK_EN to compare every read beat against the written pattern (beat n = n+1).
module axi_burst_master #(
  parameter logic [31:0] M_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
  parameter int          M_AXI_BURST_LEN          = 16,
  parameter int          M_AXI_ID_WIDTH           = 1,
  parameter int          M_AXI_ADDR_WIDTH         = 32,
  parameter int          M_AXI_DATA_WIDTH         = 32
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  input  logic                          txn_start,
  input  logic [1:0]                    txn_type,
  output logic                          txn_done,
  output logic                          txn_error,

  output logic [M_AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awlock,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  output logic [3:0]                    m_axi_awqos,
  output logic [3:0]                    m_axi_awregion,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,

  output logic [M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,

  input  logic [M_AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,

  output logic [M_AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic [3:0]                    m_axi_arregion,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,

  input  logic [M_AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(M_AXI_BURST_LEN - 1);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(M_AXI_BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t           state;
  logic             txn_start_q;
  logic             start_edge;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_next;
  logic             read_mismatch;
  logic             unused_inputs;

  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = M_AXI_ADDR_WIDTH'(M_TARGET_SLAVE_BASE_ADDR);
  assign m_axi_awlen    = 8'(M_AXI_BURST_LEN - 1);
  assign m_axi_awsize   = 3'($clog2(M_AXI_DATA_WIDTH / 8));
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'b0010;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awqos    = 4'b0000;
  assign m_axi_awregion = 4'b0000;
  assign m_axi_wstrb    = '1;

  assign m_axi_arid     = '0;
  assign m_axi_araddr   = M_AXI_ADDR_WIDTH'(M_TARGET_SLAVE_BASE_ADDR);
  assign m_axi_arlen    = 8'(M_AXI_BURST_LEN - 1);
  assign m_axi_arsize   = 3'($clog2(M_AXI_DATA_WIDTH / 8));
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0010;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arqos    = 4'b0000;
  assign m_axi_arregion = 4'b0000;

  assign start_edge = txn_start & ~txn_start_q;
  assign beat_next  = beat_cnt + CNT_W'(1);

`ifdef READ_CHECK_EN
  assign read_mismatch = (m_axi_rdata != M_AXI_DATA_WIDTH'(beat_next));
  assign unused_inputs = ^{m_axi_bid, m_axi_rid};
`else
  assign read_mismatch = 1'b0;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rdata};
`endif

  // Data beat n carries n+1, so the value presented next is always beat_next + 1.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state         <= IDLE;
      txn_start_q   <= 1'b0;
      beat_cnt      <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wlast   <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      txn_done      <= 1'b0;
      txn_error     <= 1'b0;
    end else begin
      txn_start_q <= txn_start;
      txn_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge && (txn_type == 2'b01 || txn_type == 2'b10)) begin
            txn_error <= 1'b0;
            beat_cnt  <= '0;
            if (txn_type == 2'b01) begin
              m_axi_awvalid <= 1'b1;
              state         <= WR_ADDR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wdata   <= M_AXI_DATA_WIDTH'(1);
            m_axi_wlast   <= (beat_cnt == LAST_BEAT);
            state         <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (m_axi_wready) begin
            if (m_axi_wlast) begin
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              m_axi_bready <= 1'b1;
              state        <= WR_RESP;
            end else begin
              beat_cnt    <= beat_next;
              m_axi_wdata <= M_AXI_DATA_WIDTH'(beat_next + CNT_W'(1));
              m_axi_wlast <= (beat_next == LAST_BEAT);
            end
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) txn_error <= 1'b1;
            txn_done <= 1'b1;
            state    <= DONE;
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            beat_cnt <= beat_next;
            if (m_axi_rresp != 2'b00 || read_mismatch) txn_error <= 1'b1;
            // rlast must coincide exactly with the final counted beat
            if (m_axi_rlast != (beat_next == BURST_CNT)) txn_error <= 1'b1;
            if (m_axi_rlast || beat_next == BURST_CNT) begin
              m_axi_rready <= 1'b0;
              txn_done     <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: randomized-ready slave model, directed transaction sequence,
// expectations derived from the burst rules (beat n = n+1, wlast on the final beat, error sources).
`timescale 1ns/1ps
module tb_axi_burst_master;

  localparam int LEN = 16;
  localparam int DW  = 32;
  localparam int IDW = 1;
  localparam int AW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txn_start = 1'b0;
  logic [1:0] txn_type = 2'b00;
  logic txn_done, txn_error;

  logic [IDW-1:0] m_axi_awid, m_axi_arid;
  logic [AW-1:0]  m_axi_awaddr, m_axi_araddr;
  logic [7:0]     m_axi_awlen, m_axi_arlen;
  logic [2:0]     m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]     m_axi_awburst, m_axi_arburst;
  logic           m_axi_awlock, m_axi_arlock;
  logic [3:0]     m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos, m_axi_awregion, m_axi_arregion;
  logic           m_axi_awvalid, m_axi_arvalid;
  logic           m_axi_awready = 1'b0, m_axi_arready = 1'b0;
  logic [DW-1:0]  m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic           m_axi_wlast, m_axi_wvalid;
  logic           m_axi_wready = 1'b0;
  logic [IDW-1:0] m_axi_bid = '0, m_axi_rid = '0;
  logic [1:0]     m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic           m_axi_bvalid = 1'b0, m_axi_bready;
  logic [DW-1:0]  m_axi_rdata = '0;
  logic           m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;

  int check_count = 0;
  int error_count = 0;

  // Slave knobs set by the stimulus
  logic [1:0] inj_bresp = 2'b00;
  int corrupt_beat = -1;
  int rlast_mode = 0;

  // Monitor results
  int aw_count = 0, ar_count = 0, b_count = 0, r_count = 0, done_count = 0;
  int valid_seen = 0, hold_viol = 0, w_lead = 0;
  logic [AW-1:0] aw_addr = '0, ar_addr = '0;
  logic [7:0] aw_len = '0, ar_len = '0;
  logic [2:0] aw_size = '0;
  logic [1:0] aw_burst = '0;
  logic [3:0] aw_cache = '0;
  logic [DW/8-1:0] aw_strb = '0;
  logic [DW-1:0] w_data_q[$];
  logic w_last_q[$];

  // Slave internal state
  logic [DW-1:0] mem [256];
  int w_idx = 0, r_idx = 0, r_total = 0, b_delay = 0;
  logic aw_seen = 1'b0, b_pend = 1'b0, b_fire = 1'b0, r_fire = 1'b0;
  logic prev_w_stall = 1'b0, prev_aw_stall = 1'b0, prev_wlast = 1'b0;
  logic [DW-1:0] prev_wdata = '0;

  axi_burst_master dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .txn_start(txn_start), .txn_type(txn_type), .txn_done(txn_done), .txn_error(txn_error),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  // Slave and monitor: at each falling edge decide the slave drive for the coming rising edge,
  // then log the handshakes that edge will complete.
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      b_pend = 1'b0; b_fire = 1'b0; r_fire = 1'b0; aw_seen = 1'b0;
      w_idx = 0; r_idx = 0; r_total = 0;
      prev_w_stall = 1'b0; prev_aw_stall = 1'b0;
    end else begin
      if (prev_w_stall && (!m_axi_wvalid || m_axi_wdata !== prev_wdata || m_axi_wlast !== prev_wlast)) hold_viol++;
      if (prev_aw_stall && !m_axi_awvalid) hold_viol++;
      if (m_axi_awvalid || m_axi_arvalid) valid_seen++;
      if (txn_done) done_count++;
      if (m_axi_wvalid && !aw_seen) w_lead++;

      m_axi_awready = ($urandom_range(0, 3) != 0);
      if (m_axi_awvalid && m_axi_awready) begin
        aw_count++;
        aw_addr = m_axi_awaddr; aw_len = m_axi_awlen; aw_size = m_axi_awsize;
        aw_burst = m_axi_awburst; aw_cache = m_axi_awcache;
        aw_seen = 1'b1; w_idx = 0;
      end
      prev_aw_stall = m_axi_awvalid && !m_axi_awready;

      m_axi_wready = ($urandom_range(0, 3) != 0);
      if (m_axi_wvalid && m_axi_wready) begin
        w_data_q.push_back(m_axi_wdata);
        w_last_q.push_back(m_axi_wlast);
        aw_strb = m_axi_wstrb;
        if (w_idx < 256) mem[w_idx] = m_axi_wdata;
        w_idx++;
        if (m_axi_wlast) begin
          aw_seen = 1'b0; b_pend = 1'b1; b_delay = $urandom_range(0, 3);
        end
      end
      prev_w_stall = m_axi_wvalid && !m_axi_wready;
      prev_wdata = m_axi_wdata;
      prev_wlast = m_axi_wlast;

      if (b_fire) begin
        m_axi_bvalid = 1'b0; b_fire = 1'b0;
      end else if (b_pend && !m_axi_bvalid) begin
        if (b_delay == 0) begin
          m_axi_bvalid = 1'b1; m_axi_bresp = inj_bresp; b_pend = 1'b0;
        end else begin
          b_delay--;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_fire = 1'b1; b_count++;
      end

      if (r_fire) begin
        r_idx++; r_fire = 1'b0; m_axi_rvalid = 1'b0;
      end
      if (!m_axi_rvalid && r_idx < r_total && $urandom_range(0, 3) != 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rresp = 2'b00;
        m_axi_rdata = mem[r_idx] ^ ((r_idx == corrupt_beat) ? 32'h0000_0100 : 32'h0);
        m_axi_rlast = (rlast_mode == 1) ? 1'b0 : (r_idx == r_total - 1);
      end
      if (m_axi_rvalid && m_axi_rready) begin
        r_fire = 1'b1; r_count++;
      end

      m_axi_arready = ($urandom_range(0, 3) != 0);
      if (m_axi_arvalid && m_axi_arready) begin
        ar_count++;
        ar_addr = m_axi_araddr; ar_len = m_axi_arlen;
        r_total = (rlast_mode == 2) ? 5 : int'(m_axi_arlen) + 1;
        r_idx = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    assert (observed === expected) else begin
      error_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ty, input int hold);
    txn_type = ty;
    txn_start = 1'b1;
    repeat (hold) @(posedge clk);
    #2;
    txn_start = 1'b0;
  endtask

  task automatic clearMonitor();
    aw_count = 0; ar_count = 0; b_count = 0; r_count = 0; done_count = 0;
    valid_seen = 0;
    w_data_q.delete();
    w_last_q.delete();
  endtask

  task automatic waitDone(input int target, input int budget, input string tag, output int elapsed);
    elapsed = 0;
    while (done_count < target && elapsed < budget) begin
      @(posedge clk);
      #2;
      elapsed++;
    end
    checkOutput({tag, "_done_in_time"}, 64'(done_count >= target), 64'd1);
  endtask

  // Reference: a write burst is LEN beats carrying 1..LEN, wlast only on the final beat.
  task automatic checkWriteBurst(input string tag, input int first);
    for (int n = 0; n < LEN; n++) begin
      if (first + n < w_data_q.size()) begin
        checkOutput($sformatf("%s_wdata%0d", tag, n + 1), 64'(w_data_q[first + n]), 64'(n + 1));
        checkOutput($sformatf("%s_wlast%0d", tag, n + 1), 64'(w_last_q[first + n]), 64'(n == LEN - 1));
      end
    end
  endtask

  function automatic logic expReadError(input int corrupt, input int mode);
    logic data_err;
`ifdef READ_CHECK_EN
    data_err = (corrupt >= 0);
`else
    data_err = 1'b0;
`endif
    return data_err || (mode != 0);
  endfunction

  task automatic runRead(input string tag, input int corrupt, input int mode, input int beats);
    int el;
    clearMonitor();
    corrupt_beat = corrupt;
    rlast_mode = mode;
    applyStimulus(2'b10, 1);
    waitDone(1, 400, tag, el);
    repeat (10) @(posedge clk);
    #2;
    checkOutput({tag, "_done_count"}, 64'(done_count), 64'd1);
    checkOutput({tag, "_r_beats"}, 64'(r_count), 64'(beats));
    checkOutput({tag, "_txn_error"}, 64'(txn_error), 64'(expReadError(corrupt, mode)));
    corrupt_beat = -1;
    rlast_mode = 0;
  endtask

  task automatic runWrite(input string tag, input logic [1:0] bresp);
    int el;
    clearMonitor();
    inj_bresp = bresp;
    applyStimulus(2'b01, 1);
    waitDone(1, 400, tag, el);
    repeat (10) @(posedge clk);
    #2;
    checkOutput({tag, "_done_count"}, 64'(done_count), 64'd1);
    checkOutput({tag, "_w_beats"}, 64'(w_data_q.size()), 64'(LEN));
    checkOutput({tag, "_txn_error"}, 64'(txn_error), 64'(bresp != 2'b00));
    inj_bresp = 2'b00;
  endtask

  initial begin
    int el;
    int reached;
    logic [1:0] ops [7] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_outputs",
                64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, txn_done, txn_error}),
                64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    $display("[TB] write burst with start held 5 cycles");
    clearMonitor();
    applyStimulus(2'b01, 5);
    waitDone(1, 400, "t1", el);
    repeat (10) @(posedge clk);
    #2;
    checkOutput("t1_aw_count", 64'(aw_count), 64'd1);
    checkOutput("t1_awaddr", 64'(aw_addr), 64'h4000_0000);
    checkOutput("t1_awlen", 64'(aw_len), 64'(LEN - 1));
    checkOutput("t1_awsize", 64'(aw_size), 64'd2);
    checkOutput("t1_awburst", 64'(aw_burst), 64'd1);
    checkOutput("t1_awcache", 64'(aw_cache), 64'd2);
    checkOutput("t1_wstrb", 64'(aw_strb), 64'hF);
    checkOutput("t1_w_beats", 64'(w_data_q.size()), 64'(LEN));
    checkWriteBurst("t1", 0);
    checkOutput("t1_b_count", 64'(b_count), 64'd1);
    checkOutput("t1_done_count", 64'(done_count), 64'd1);
    checkOutput("t1_txn_error", 64'(txn_error), 64'd0);

    $display("[TB] read burst back");
    clearMonitor();
    applyStimulus(2'b10, 1);
    waitDone(1, 400, "t2", el);
    repeat (10) @(posedge clk);
    #2;
    checkOutput("t2_ar_count", 64'(ar_count), 64'd1);
    checkOutput("t2_araddr", 64'(ar_addr), 64'h4000_0000);
    checkOutput("t2_arlen", 64'(ar_len), 64'(LEN - 1));
    checkOutput("t2_r_beats", 64'(r_count), 64'(LEN));
    checkOutput("t2_done_count", 64'(done_count), 64'd1);
    checkOutput("t2_txn_error", 64'(txn_error), 64'd0);

    $display("[TB] W,W,R,R,W,R,R sequence with an extra start edge mid-burst");
    clearMonitor();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(ops[i], 1);
      el = 1;
      if (i == 2) begin
        repeat (3) @(posedge clk);
        #2;
        applyStimulus(2'b01, 2);
        txn_type = 2'b10;
        el += 5;
      end
      begin
        int w;
        waitDone(i + 1, 300, $sformatf("t3_op%0d", i), w);
        el += w;
      end
      if (el < 50) repeat (50 - el) @(posedge clk);
      #2;
    end
    repeat (10) @(posedge clk);
    #2;
    checkOutput("t3_done_count", 64'(done_count), 64'd7);
    checkOutput("t3_aw_count", 64'(aw_count), 64'd3);
    checkOutput("t3_ar_count", 64'(ar_count), 64'd4);
    checkOutput("t3_b_count", 64'(b_count), 64'd3);
    checkOutput("t3_w_beats", 64'(w_data_q.size()), 64'(3 * LEN));
    checkWriteBurst("t3_wr3", 2 * LEN);
    checkOutput("t3_r_beats", 64'(r_count), 64'(4 * LEN));
    checkOutput("t3_txn_error", 64'(txn_error), 64'd0);

    $display("[TB] types 00 and 11 ignored");
    clearMonitor();
    applyStimulus(2'b00, 2);
    repeat (20) @(posedge clk);
    #2;
    applyStimulus(2'b11, 2);
    repeat (20) @(posedge clk);
    #2;
    checkOutput("t4_valid_seen", 64'(valid_seen), 64'd0);
    checkOutput("t4_done_count", 64'(done_count), 64'd0);

    $display("[TB] error reporting");
    runWrite("t5_bresp_slverr", 2'b10);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("t5_error_sticky", 64'(txn_error), 64'd1);
    runRead("t5_corrupt_beat3", 2, 0, LEN);
    runRead("t5_rlast_missing", -1, 1, LEN);
    runRead("t5_rlast_early", -1, 2, 5);
    runRead("t5_clean_read", -1, 0, LEN);

    $display("[TB] reset during W beat 5");
    clearMonitor();
    applyStimulus(2'b01, 1);
    reached = 0;
    for (int c = 0; c < 300; c++) begin
      if (w_data_q.size() >= 4) begin
        reached = 1;
        break;
      end
      @(posedge clk);
      #2;
    end
    checkOutput("t6_reached_beat5", 64'(reached), 64'd1);
    checkOutput("t6_beat5_data", 64'(m_axi_wdata), 64'd5);
    rst = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("t6_after_reset",
                64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, txn_done}),
                64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    runWrite("t6_restart", 2'b00);
    checkWriteBurst("t6_restart", 0);

    checkOutput("hold_violations", 64'(hold_viol), 64'd0);
    checkOutput("w_before_aw", 64'(w_lead), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
